// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: time-stamps per-channel spike pulses and serialises them
// by fixed priority into {channel_id, timestamp} address-event words. Words are
// queued in a show-ahead FIFO and drained over a valid/ready handshake.
// Events overwritten while still waiting for a grant set a sticky overflow flag.
module spike_aer_encoder #(
    parameter int NUM_CH = 4,
    parameter int TS_W   = 6,
    parameter int DEPTH  = 8,
    localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int WORD_W = ID_W + TS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] spike_in,
    input  logic              enable,
    output logic [WORD_W-1:0] aer_data,
    output logic              aer_valid,
    input  logic              aer_ready,
    output logic [AW:0]       fifo_count,
    output logic              overflow
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [TS_W-1:0]   ts;
    logic [NUM_CH-1:0] pending;
    logic [TS_W-1:0]   ts_latch [NUM_CH];
    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    logic [NUM_CH-1:0] capture;
    logic [NUM_CH-1:0] grant_oh;
    logic [ID_W-1:0]   grant_id;
    logic              grant_vld;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              lost;

    // Spikes only count while enabled; the full test uses the pre-pop count.
    assign capture   = spike_in & {NUM_CH{enable}};
    assign fifo_full = (fifo_count == FULL_CNT);
    assign push      = grant_vld;
    assign aer_valid = (fifo_count != '0);
    assign pop       = aer_valid & aer_ready;
    assign aer_data  = aer_valid ? mem[rd_ptr] : '0;

    // A waiting (ungranted) event hit by a new capture is overwritten and lost.
    assign lost = |(capture & pending & ~grant_oh);

    // Fixed-priority arbiter: the lowest-index pending channel wins if the FIFO has room.
    always_comb begin
        grant_id = '0;
        grant_oh = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pending[c]) grant_id = ID_W'(c);
        end
        grant_vld = (|pending) && !fifo_full;
        if (grant_vld) grant_oh[grant_id] = 1'b1;
    end

    // Free-running timestamp, advancing only while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else if (enable) begin
            ts <= ts + 1'b1;
        end
    end

    // Per-channel capture: a new spike always wins over the clear from a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int c = 0; c < NUM_CH; c++) ts_latch[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (capture[c]) begin
                    pending[c]  <= 1'b1;
                    ts_latch[c] <= ts;
                end else if (grant_oh[c]) begin
                    pending[c] <= 1'b0;
                end
            end
        end
    end

    // Sticky loss flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (lost) begin
            overflow <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage: the granted channel's word is written at the tail.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {grant_id, ts_latch[grant_id]};
    end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed testbench for spike_aer_encoder (NUM_CH=4, TS_W=6, DEPTH=8).
// Words are {id[1:0], ts[5:0]}; expected values are hand-computed per step.
module tb_spike_aer_encoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] spike_in;
    logic       enable;
    logic [7:0] aer_data;
    logic       aer_valid;
    logic       aer_ready;
    logic [3:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    spike_aer_encoder #(.NUM_CH(4), .TS_W(6), .DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .enable     (enable),
        .aer_data   (aer_data),
        .aer_valid  (aer_valid),
        .aer_ready  (aer_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset pulse spanning one edge; leaves the timestamp at 0.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        spike_in  = 4'b0000;
        enable    = 1'b0;
        aer_ready = 1'b0;
        #2;
        check("rst_valid", aer_valid, 0);
        check("rst_data", aer_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        tick_n(2);
        rst_n     = 1'b1;
        enable    = 1'b1;
        aer_ready = 1'b1;

        // Single spike on channel 1 at ts=5
        tick_n(5);
        spike_in = 4'b0010;
        tick();
        spike_in = 4'b0000;
        check("t1_lat_valid", aer_valid, 0);
        check("t1_lat_data", aer_data, 0);
        tick();
        check("t1_valid", aer_valid, 1);
        check("t1_data", aer_data, 8'h45);
        check("t1_count", fifo_count, 1);
        tick();
        check("t1_empty", aer_valid, 0);
        check("t1_count0", fifo_count, 0);
        check("t1_ovf", overflow, 0);

        // Four simultaneous spikes at ts=10 (ts now 8)
        tick_n(2);
        spike_in = 4'b1111;
        tick();
        spike_in = 4'b0000;
        tick();
        check("t2_w0", aer_data, 8'h0A);
        check("t2_cnt0", fifo_count, 1);
        tick();
        check("t2_w1", aer_data, 8'h4A);
        tick();
        check("t2_w2", aer_data, 8'h8A);
        tick();
        check("t2_w3", aer_data, 8'hCA);
        check("t2_cnt3", fifo_count, 1);
        tick();
        check("t2_empty", aer_valid, 0);
        check("t2_ovf", overflow, 0);

        // Back-pressure: 9 spikes on ch0 at ts=16,18,...,32
        aer_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            spike_in = 4'b0001;
            tick();
            spike_in = 4'b0000;
            tick();
        end
        check("t3_full", fifo_count, 8);
        check("t3_head", aer_data, 8'h10);
        tick_n(2);
        check("t3_hold_full", fifo_count, 8);
        check("t3_hold_head", aer_data, 8'h10);
        check("t3_ovf", overflow, 0);
        aer_ready = 1'b1;
        tick();
        check("t3_no_push_on_full", fifo_count, 7);
        for (int j = 1; j < 9; j++) begin
            check($sformatf("t3_word%0d", j), aer_data, {2'd0, 6'(16 + 2 * j)});
            tick();
        end
        check("t3_drained", aer_valid, 0);
        check("t3_cnt0", fifo_count, 0);

        // Overflow: ch0 held high fills the FIFO, ch2 spikes at ts=3 and ts=7
        do_reset();
        aer_ready = 1'b0;
        for (int e = 0; e < 8; e++) begin
            spike_in = ((e == 3) || (e == 7)) ? 4'b0101 : 4'b0001;
            tick();
            if (e == 3) check("t4_ovf_early", overflow, 0);
        end
        spike_in = 4'b0000;
        check("t4_ovf_set", overflow, 1);
        tick();
        check("t4_full", fifo_count, 8);
        check("t4_head", aer_data, 8'h00);
        aer_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            check($sformatf("t4_word%0d", j), aer_data, (j < 8) ? {2'd0, 6'(j)} : 8'h87);
            tick();
        end
        check("t4_drained", aer_valid, 0);
        check("t4_ovf_sticky", overflow, 1);

        // Timestamp wrap: ts is 18 here; spike ch1 at ts=63 then ch3 at ts=0
        tick_n(45);
        spike_in = 4'b0010;
        tick();
        spike_in = 4'b1000;
        tick();
        spike_in = 4'b0000;
        check("t5_ts63", aer_data, 8'h7F);
        tick();
        check("t5_ts0", aer_data, 8'hC0);
        tick();
        check("t5_empty", aer_valid, 0);

        // enable=0: spikes ignored, timestamp held at 3
        enable   = 1'b0;
        spike_in = 4'b1111;
        tick_n(2);
        spike_in = 4'b0000;
        check("t5_dis_valid", aer_valid, 0);
        check("t5_dis_count", fifo_count, 0);
        tick();
        check("t5_dis_valid2", aer_valid, 0);
        enable   = 1'b1;
        spike_in = 4'b0100;
        tick();
        spike_in = 4'b0000;
        tick();
        check("t5_ts_held", aer_data, 8'h83);
        tick();
        check("t5_empty2", aer_valid, 0);

        // Reset mid-operation with 3 words queued (ts is 6 here)
        aer_ready = 1'b0;
        spike_in  = 4'b0111;
        tick();
        spike_in = 4'b0000;
        tick_n(3);
        check("t6_count3", fifo_count, 3);
        check("t6_head", aer_data, 8'h06);
        check("t6_ovf_pre", overflow, 1);
        rst_n = 1'b0;
        #1;
        check("t6_valid", aer_valid, 0);
        check("t6_data", aer_data, 0);
        check("t6_count", fifo_count, 0);
        check("t6_ovf", overflow, 0);
        tick();
        rst_n     = 1'b1;
        aer_ready = 1'b1;
        spike_in  = 4'b1000;
        tick();
        spike_in = 4'b0000;
        tick();
        check("t6_first_ts0", aer_data, 8'hC0);
        tick();
        check("t6_pending_cleared", aer_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
